// File: rtl/biss_poll_scheduler.sv
// biss_poll_scheduler
// Shares one BiSS-C position reader between NUM_CH encoder channels. Every
// PERIOD clocks a round starts: each channel enabled in ch_mask gets one
// reader transaction (with timeout), an optional CRC6 check, and a published
// result tagged with its channel index.
//
// Optional feature macro: BISS_CRC_CHECK_EN. When it is defined, CHECK runs a
// bit-serial CRC6 (x^6+x+1, seed 0) over {position, err, warn}. When it is
// undefined, CHECK takes one clock and crc_fail is always 0.
//
// Ports:
//   clk, reset (async, active-high)
//   enable, ch_mask, fault_clr       : control from the motion side
//   rd_start, rd_sel                 : reader start pulse / channel select
//   rd_done, rd_position, rd_err,
//   rd_warn, rd_crc                  : reader result
//   out_valid, out_ch, out_position,
//   out_status {timeout,crc_fail,warn,err}
//   round_done, overrun, ch_fault    : round/health reporting
module biss_poll_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int PERIOD  = 5000,
  parameter int TIMEOUT = 4000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              fault_clr,
  output logic              rd_start,
  output logic [CH_W-1:0]   rd_sel,
  input  logic              rd_done,
  input  logic [31:0]       rd_position,
  input  logic              rd_err,
  input  logic              rd_warn,
  input  logic [5:0]        rd_crc,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [31:0]       out_position,
  output logic [3:0]        out_status,
  output logic              round_done,
  output logic              overrun,
  output logic [NUM_CH-1:0] ch_fault
);

  localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int TW = ($clog2(TIMEOUT) > 6) ? $clog2(TIMEOUT) : 6;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_TICK, S_START, S_WAIT_DONE, S_CHECK, S_PUBLISH, S_NEXT
  } state_t;

  // Lowest set bit of m at or above position start; MSB of result = found.
  function automatic logic [CH_W:0] find_from(input logic [NUM_CH-1:0] m,
                                              input logic [CH_W:0]   start);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (i >= int'(start))) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [PW-1:0]     cnt_q;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic              rd_start_q, rd_start_d;
  logic              out_valid_q, out_valid_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [31:0]       out_pos_q, out_pos_d;
  logic [3:0]        out_status_q, out_status_d;
  logic              round_done_q, round_done_d;
  logic              overrun_q, overrun_d;
  logic [NUM_CH-1:0] ch_fault_q, ch_fault_d;
  logic [31:0]       pos_q;
  logic              err_q, warn_q;
  logic              tick;
  logic [CH_W:0]     low, nxt;
  logic              pub_en, pub_to, pub_fail;
  logic              capture;

`ifdef BISS_CRC_CHECK_EN
  logic [5:0]  crc_q, lfsr_q;
  logic [33:0] sh_q;

  function automatic logic [5:0] crc6_step(input logic [5:0] c, input logic b);
    logic fb;
    fb = b ^ c[5];
    return {c[4:0], 1'b0} ^ {4'b0000, fb, fb};
  endfunction
`else
  logic unused_crc;
  assign unused_crc = ^rd_crc;
`endif

  assign tick    = enable && (cnt_q == PW'(PERIOD - 1));
  assign low     = find_from(ch_mask, '0);
  assign nxt     = find_from(mask_q, {1'b0, idx_q} + (CH_W + 1)'(1));
  assign capture = (state_q == S_WAIT_DONE) && rd_done;

  // Round timebase: held at 0 while disabled, free-running otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          cnt_q <= '0;
    else if (!enable)                   cnt_q <= '0;
    else if (cnt_q == PW'(PERIOD - 1))  cnt_q <= '0;
    else                                cnt_q <= cnt_q + PW'(1);
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    idx_d        = idx_q;
    to_cnt_d     = to_cnt_q;
    rd_start_d   = 1'b0;
    out_valid_d  = 1'b0;
    out_ch_d     = out_ch_q;
    out_pos_d    = out_pos_q;
    out_status_d = out_status_q;
    round_done_d = 1'b0;
    overrun_d    = 1'b0;
    ch_fault_d   = fault_clr ? '0 : ch_fault_q;
    pub_en       = 1'b0;
    pub_to       = 1'b0;
    pub_fail     = 1'b0;

    // A tick that lands mid-round is dropped and flagged.
    if (tick && (state_q != S_IDLE) && (state_q != S_WAIT_TICK)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: if (enable) state_d = S_WAIT_TICK;
      S_WAIT_TICK: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (tick) begin
          mask_d = ch_mask;
          idx_d  = low[CH_W-1:0];
          if (!low[CH_W]) begin
            round_done_d = 1'b1;
          end else begin
            state_d    = S_START;
            rd_start_d = 1'b1;
          end
        end
      end
      S_START: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // rd_done takes priority over an expiring timeout.
        if (rd_done) begin
          to_cnt_d = '0;
          state_d  = S_CHECK;
        end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
          pub_en = 1'b1;
          pub_to = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_CHECK: begin
`ifdef BISS_CRC_CHECK_EN
        // 34 shift clocks, then one compare clock against the inverted CRC.
        if (to_cnt_q == TW'(34)) begin
          pub_en   = 1'b1;
          pub_fail = (lfsr_q != ~crc_q);
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
`else
        pub_en = 1'b1;
`endif
      end
      S_PUBLISH: begin
        state_d = S_NEXT;
        if (!nxt[CH_W]) round_done_d = 1'b1;
      end
      S_NEXT: begin
        if (nxt[CH_W]) begin
          idx_d      = nxt[CH_W-1:0];
          state_d    = S_START;
          rd_start_d = 1'b1;
        end else begin
          state_d = enable ? S_WAIT_TICK : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Result registers load on entry to PUBLISH so they are visible during it.
    if (pub_en) begin
      state_d      = S_PUBLISH;
      out_valid_d  = 1'b1;
      out_ch_d     = idx_q;
      out_pos_d    = pub_to ? 32'd0 : pos_q;
      out_status_d = {pub_to, pub_fail, warn_q & ~pub_to, err_q & ~pub_to};
      if (pub_to || pub_fail) ch_fault_d[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      idx_q        <= '0;
      to_cnt_q     <= '0;
      rd_start_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_pos_q    <= '0;
      out_status_q <= '0;
      round_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      ch_fault_q   <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      idx_q        <= idx_d;
      to_cnt_q     <= to_cnt_d;
      rd_start_q   <= rd_start_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_pos_q    <= out_pos_d;
      out_status_q <= out_status_d;
      round_done_q <= round_done_d;
      overrun_q    <= overrun_d;
      ch_fault_q   <= ch_fault_d;
    end
  end

  // Reader result capture; data path carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      pos_q  <= rd_position;
      err_q  <= rd_err;
      warn_q <= rd_warn;
    end
  end

`ifdef BISS_CRC_CHECK_EN
  always_ff @(posedge clk) begin
    if (capture) begin
      crc_q  <= rd_crc;
      sh_q   <= {rd_position, rd_err, rd_warn};
      lfsr_q <= '0;
    end else if ((state_q == S_CHECK) && (to_cnt_q < TW'(34))) begin
      sh_q   <= {sh_q[32:0], 1'b0};
      lfsr_q <= crc6_step(lfsr_q, sh_q[33]);
    end
  end
`endif

  assign rd_start     = rd_start_q;
  assign rd_sel       = idx_q;
  assign out_valid    = out_valid_q;
  assign out_ch       = out_ch_q;
  assign out_position = out_pos_q;
  assign out_status   = out_status_q;
  assign round_done   = round_done_q;
  assign overrun      = overrun_q;
  assign ch_fault     = ch_fault_q;

endmodule
